// File: rtl/mult_seq_pkg.sv
// Shared types and defaults for the sequential multiplier controller.
// Holds the controller state encoding and default operand width / cycle count.
package mult_seq_pkg;

  localparam int N_DEF  = 8;
  localparam int CC_DEF = N_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_seq_ctrl.sv
// Controller sequencing one serial (bit-per-cycle) multiplier operation.
// Ports:
//   clk        - clock, all state on the rising edge
//   rst        - synchronous active-low reset
//   in_valid   - operand pair offered
//   in_ready   - operands accepted (IDLE only)
//   in_a       - multiplicand, N bits, presented in parallel
//   in_b       - multiplier, N bits, serialised LSB-first
//   g_input    - multiplicand to the serial multiplier
//   e_input    - current multiplier bit to the serial multiplier
//   mult_rst   - active-high clear pulse to the serial multiplier
//   o_in       - 2N-bit product bus from the serial multiplier
//   out_valid  - product available (HOLD only)
//   out_ready  - consumer accepts product
//   out_data   - captured 2N-bit product
// Build option MULT_SEQ_ZERO_SKIP_EN: an accepted in_b of zero skips the
// multiplier and goes straight to HOLD with a zero product.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CC = N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic [N-1:0]   g_input,
  output logic           e_input,
  output logic           mult_rst,
  input  logic [2*N-1:0] o_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_data
);

  localparam int CW = (CC > 1) ? $clog2(CC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CC - 1);

  state_t        state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign cnt_nxt = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      g_input   <= '0;
      e_input   <= 1'b0;
      mult_rst  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          mult_rst <= 1'b0;
          g_input  <= '0;
          e_input  <= 1'b0;
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            in_ready <= 1'b0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
            // Zero multiplier: product is known, bypass the multiplier.
            if (in_b == '0) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_data  <= '0;
            end else begin
              state    <= CLEAR;
              mult_rst <= 1'b1;
            end
`else
            state    <= CLEAR;
            mult_rst <= 1'b1;
`endif
          end else begin
            // Ready rises one cycle after reset or a drained HOLD.
            in_ready <= 1'b1;
          end
        end
        CLEAR: begin
          state    <= RUN;
          mult_rst <= 1'b0;
          cnt      <= '0;
          g_input  <= a_q;
          e_input  <= b_q[0];
        end
        RUN: begin
          if (cnt == CNT_LAST) begin
            // o_in already includes the last bit presented this cycle.
            out_data  <= o_in;
            out_valid <= 1'b1;
            state     <= HOLD;
            cnt       <= '0;
            g_input   <= '0;
            e_input   <= 1'b0;
          end else begin
            cnt     <= cnt_nxt;
            e_input <= b_q[cnt_nxt];
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural serial multiplier.
// Checks latency, products, bit sequencing, stalls, reset and back-to-back.
module tb_mult_seq_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] g_input;
  logic         e_input;
  logic         mult_rst;
  logic [15:0]  o_in;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MULT_SEQ_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 10;
`endif

  always #5 clk = ~clk;

  mult_seq_ctrl #(.N(N), .CC(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .g_input   (g_input),
    .e_input   (e_input),
    .mult_rst  (mult_rst),
    .o_in      (o_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Shift-add serial multiplier; o_in shows the sum including the
  // bit presented this cycle.
  logic [15:0] acc;
  logic [8:0]  sum;
  assign sum  = {1'b0, acc[15:8]} + (e_input ? {1'b0, g_input} : 9'd0);
  assign o_in = {sum, acc[7:1]};
  always @(posedge clk) begin
    if (mult_rst) acc <= '0;
    else          acc <= o_in;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, " vld_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic do_op(input logic [7:0]  a,
                       input logic [7:0]  b,
                       input logic [15:0] exp_p,
                       input int          exp_lat,
                       input int          stall,
                       input string       tag);
    int         lat;
    int         k;
    logic [7:0] eseq;
    logic [7:0] g2;
    logic       mr1;
    eseq = '0;
    g2   = '0;
    mr1  = 1'b0;
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (lat < 40) begin
      @(negedge clk);
      if (lat == 1) mr1 = mult_rst;
      if (lat == 2) g2 = g_input;
      if (lat >= 2 && lat <= 9) eseq[lat-2] = e_input;
      if (out_valid) break;
      lat++;
    end
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check({tag, " prod"}, 32'(out_data), 32'(exp_p));
    if (exp_lat == 10) begin
      check({tag, " clr"}, 32'(mr1), 32'd1);
      check({tag, " eseq"}, 32'(eseq), 32'(b));
      check({tag, " g"}, 32'(g2), 32'(a));
    end else begin
      check({tag, " noclr"}, 32'(mr1), 32'd0);
    end
    // Stall in HOLD while offering a new pair that must be ignored.
    in_a     = 8'hA5;
    in_b     = 8'h5A;
    in_valid = (stall > 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, " st_data"}, 32'(out_data), 32'(exp_p));
      check({tag, " st_rdy"}, 32'(in_ready), 32'd0);
      check({tag, " st_vld"}, 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst rdy", 32'(in_ready), 32'd0);
    check("rst vld", 32'(out_valid), 32'd0);
    check("rst data", 32'(out_data), 32'd0);
    check("rst g", 32'(g_input), 32'd0);
    check("rst e", 32'(e_input), 32'd0);
    check("rst mrst", 32'(mult_rst), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("post rdy", 32'(in_ready), 32'd1);
    check("post mrst", 32'(mult_rst), 32'd0);

    do_op(8'h03, 8'h05, 16'h000F, 10, 0, "3x5");
    do_op(8'hFF, 8'hFF, 16'hFE01, 10, 0, "ffxff");
    do_op(8'h81, 8'h6C, 16'h366C, 10, 5, "stall");
    do_op(8'h9C, 8'h00, 16'h0000, ZERO_LAT, 0, "b0");
    do_op(8'h01, 8'h80, 16'h0080, 10, 0, "msb");

    // Reset in the middle of RUN (cnt == 3 is the fifth cycle after accept).
    @(negedge clk);
    in_a     = 8'h55;
    in_b     = 8'hAA;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid vld", 32'(out_valid), 32'd0);
    check("mid mrst", 32'(mult_rst), 32'd1);
    check("mid rdy", 32'(in_ready), 32'd0);
    check("mid ge", 32'({g_input, e_input}), 32'd0);
    check("mid data", 32'(out_data), 32'd0);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid noval", 32'(seen), 32'd0);
    do_op(8'h07, 8'h09, 16'h003F, 10, 0, "after");

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    in_a      = 8'h12;
    in_b      = 8'h34;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_a = 8'h0B;
    in_b = 8'hC5;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b lat1", 32'(lat), 32'd10);
    check("b2b prod1", 32'(out_data), 32'h03A8);
    @(negedge clk);
    check("b2b gap_rdy", 32'(in_ready), 32'd1);
    check("b2b gap_vld", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    check("b2b acc2", 32'(in_ready), 32'd0);
    check("b2b clr2", 32'(mult_rst), 32'd1);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b lat2", 32'(lat), 32'd10);
    check("b2b prod2", 32'(out_data), 32'h0877);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b end", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits.
REQ-002 SHALL have parameter CC, default N, number of serial multiplier cycles per operation (CC == N).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operand pair offered.
REQ-006 SHALL have port in_ready, output, 1, controller accepts operands.
REQ-007 SHALL have port in_a, input, N, multiplicand, held parallel.
REQ-008 SHALL have port in_b, input, N, multiplier, serialised LSB-first.
REQ-009 SHALL have port g_input, output, N, multiplicand to serial multiplier.
REQ-010 SHALL have port e_input, output, 1, current multiplier bit to serial multiplier.
REQ-011 SHALL have port mult_rst, output, 1, active-high clear pulse to serial multiplier state.
REQ-012 SHALL have port o_in, input, 2N, product bus from serial multiplier.
REQ-013 SHALL have port out_valid, output, 1, product available.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts product.
REQ-015 SHALL have port out_data, output, 2N, captured product.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, RUN, HOLD.
REQ-017 SHALL assert in_ready only in IDLE and accept on in_valid&in_ready, latching in_a/in_b into internal registers.
REQ-018 SHALL, after acceptance, enter CLEAR for exactly one cycle with registered mult_rst=1, e_input=0, g_input=0.
REQ-019 SHALL, in RUN, drive g_input=latched a and e_input=latched b[cnt] for cnt=0..CC-1, one bit per cycle, cnt incrementing each cycle.
REQ-020 SHALL capture o_in into out_data on the RUN cycle where cnt==CC-1, then enter HOLD.
REQ-021 SHALL drive g_input=0 and e_input=0 outside RUN, and mult_rst=0 outside CLEAR and reset.
REQ-022 SHALL assert out_valid only in HOLD, hold out_data stable until out_valid&out_ready, then return to IDLE.
REQ-023 SHALL yield out_valid exactly CC+2 cycles after the accept edge (10 for N=8).
REQ-024 SHALL ignore in_valid outside IDLE and out_ready outside HOLD.
REQ-025 SHALL compute unsigned products only; out_data width 2N, no truncation (0xFF*0xFF=0xFE01).
REQ-026 SHALL keep cnt width $clog2(CC); cnt SHALL NOT wrap within a RUN; cnt=0 on RUN entry.

Reset
REQ-027 SHALL, while rst==0 at a clock edge, force state=IDLE, cnt=0, out_valid=0, out_data=0, g_input=0, e_input=0, mult_rst=1, in_ready=0.
REQ-028 SHALL, on reset during CLEAR/RUN/HOLD, abandon the operation without producing out_valid; in_ready=1 on the first cycle after rst returns high.

Configuration
REQ-029 SHALL support macro MULT_SEQ_ZERO_SKIP_EN; when defined, accepted in_b==0 SHALL go IDLE->HOLD directly with out_data=0, out_valid one cycle after accept, no mult_rst pulse.
REQ-030 SHALL, without MULT_SEQ_ZERO_SKIP_EN, treat in_b==0 as a normal CC+2-cycle operation.

Structure
REQ-031 SHALL place the state enum typedef and default N/CC localparams in shared package mult_seq_pkg.
REQ-032 SHALL be a single flat module with no sub-modules; the serial multiplier is instantiated beside it by the parent.

Verification
REQ-033 SHALL cover: a=0x03,b=0x05 with a serial multiplier connected -> out_data=0x000F, out_valid at accept+10.
REQ-034 SHALL cover: a=0xFF,b=0xFF -> out_data=0xFE01; e_input sequence 1,1,1,1,1,1,1,1 over RUN.
REQ-035 SHALL cover: out_ready held low 5 cycles in HOLD -> out_data stable, in_ready=0, in_valid ignored throughout.
REQ-036 SHALL cover: rst low at RUN cnt=3 -> next cycle outputs at reset values, mult_rst=1, no out_valid; new op afterward correct.
REQ-037 SHALL cover: b=0x00 with MULT_SEQ_ZERO_SKIP_EN -> out_valid at accept+1, out_data=0; without the macro -> out_valid at accept+10, out_data=0.
REQ-038 SHALL cover: back-to-back ops, in_valid held high -> second accept one cycle after first out_valid&out_ready, both products correct.
